div_iter: RTL and testbench

- Parametrised multi-cycle iterative divider for the EX stage.
- Computes quotient and remainder for DIV/DIVU and returns them packed as {HI,LO} for the HILO write path.
- The EX stage drives start_i and holds the pipeline stall while the divider is busy.
- Successor to the single-cycle combinational multiply path: configurable width, configurable bits retired per cycle, signed/unsigned mode, and annulment by flush.

---
 rtl/div_iter_pkg.sv | 21 ++
 rtl/div_step.sv | 24 ++
 rtl/div_iter.sv | 145 ++++++++++++++
 tb/tb_div_iter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/div_iter_pkg.sv
// Shared state codes, handshake constants and parameter checks for the
// iterative divider.
package div_iter_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    function automatic bit steps_legal(input int data_w, input int steps);
        return ((steps == 1) || (steps == 2) || (steps == 4)) && ((data_w % steps) == 0);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring trial-subtraction step: shift in a dividend bit, subtract
// the divisor if it fits, and report the resulting quotient bit.
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_in,
    input  logic         dividend_bit,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_out,
    output logic         q_bit
);

    logic [W:0] minuend;
    logic [W:0] diff;

    // rem_in < divisor always holds, so a successful subtract fits in W bits.
    always_comb begin
        minuend = {rem_in, dividend_bit};
        diff    = minuend - {1'b0, divisor};
        q_bit   = (minuend >= {1'b0, divisor});
        rem_out = q_bit ? diff[W-1:0] : minuend[W-1:0];
    end

endmodule

// File: rtl/div_iter.sv
// Multi-cycle restoring divider for DIV/DIVU; returns {remainder, quotient}
// and retires STEPS_PER_CYCLE quotient bits per clock.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output div_state_e            dbg_state
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int S     = STEPS_PER_CYCLE;

    generate
        if (!steps_legal(DATA_W, STEPS_PER_CYCLE)) begin : g_bad_steps
            $error("div_iter: STEPS_PER_CYCLE must be 1, 2 or 4 and divide DATA_W");
        end
    endgenerate

    div_state_e            state, state_n;
    logic [DATA_W-1:0]     dq, dq_n;       // dividend bits shift out, quotient bits shift in
    logic [DATA_W-1:0]     rem, rem_n;
    logic [DATA_W-1:0]     dvs, dvs_n;
    logic                  sign_q, sign_q_n;
    logic                  sign_r, sign_r_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [2*DATA_W-1:0]   result, result_n;

    logic [DATA_W-1:0]     rem_chain [S+1];
    logic [DATA_W-1:0]     dq_chain  [S+1];
    logic [S-1:0]          q_bits;

    assign rem_chain[0] = rem;
    assign dq_chain[0]  = dq;

    generate
        for (genvar g = 0; g < S; g++) begin : g_step
            div_step #(.W(DATA_W)) u_step (
                .rem_in       (rem_chain[g]),
                .dividend_bit (dq_chain[g][DATA_W-1]),
                .divisor      (dvs),
                .rem_out      (rem_chain[g+1]),
                .q_bit        (q_bits[g])
            );
            assign dq_chain[g+1] = {dq_chain[g][DATA_W-2:0], q_bits[g]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= DIV_FREE;
            dq     <= '0;
            rem    <= '0;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            cnt    <= '0;
            result <= '0;
        end else begin
            state  <= state_n;
            dq     <= dq_n;
            rem    <= rem_n;
            dvs    <= dvs_n;
            sign_q <= sign_q_n;
            sign_r <= sign_r_n;
            cnt    <= cnt_n;
            result <= result_n;
        end
    end

    always_comb begin
        state_n  = state;
        dq_n     = dq;
        rem_n    = rem;
        dvs_n    = dvs;
        sign_q_n = sign_q;
        sign_r_n = sign_r;
        cnt_n    = cnt;
        result_n = result;

        case (state)
            DIV_FREE: begin
                result_n = '0;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_n = DIV_BYZERO;
                    end else begin
                        state_n  = DIV_ON;
                        dq_n     = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
                        dvs_n    = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
                        sign_q_n = signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        sign_r_n = signed_div_i & opdata1_i[DATA_W-1];
                        rem_n    = '0;
                        cnt_n    = '0;
                    end
                end
            end
            DIV_BYZERO: begin
                result_n = '0;
                state_n  = annul_i ? DIV_FREE : DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                end else begin
                    rem_n = rem_chain[S];
                    dq_n  = dq_chain[S];
                    cnt_n = cnt + CNT_W'(S);
                    // Last batch of steps: fix up signs and publish the result.
                    if (cnt == CNT_W'(DATA_W - S)) begin
                        result_n = {sign_r ? -rem_chain[S] : rem_chain[S],
                                    sign_q ? -dq_chain[S]  : dq_chain[S]};
                        state_n  = DIV_END;
                    end
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_n  = DIV_FREE;
                    result_n = '0;
                end
            end
            default: begin
                state_n  = DIV_FREE;
                result_n = '0;
            end
        endcase
    end

    assign ready_o   = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
    assign result_o  = result;
    assign dbg_state = state;

endmodule

// File: tb/tb_div_iter.sv
// Directed and randomized checks of div_iter against an arithmetic model,
// on one instance retiring 1 bit per clock and one retiring 2.
module tb_div_iter;
  import div_iter_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          sgn1 = 1'b0, start1 = 1'b0, annul1 = 1'b0;
  logic [W-1:0]  a1 = '0, b1 = '0;
  logic [2*W-1:0] res1;
  logic          rdy1;
  div_state_e    st1;

  logic          sgn2 = 1'b0, start2 = 1'b0, annul2 = 1'b0;
  logic [W-1:0]  a2 = '0, b2 = '0;
  logic [2*W-1:0] res2;
  logic          rdy2;
  div_state_e    st2;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_iter #(.DATA_W(W), .STEPS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .signed_div_i(sgn1), .opdata1_i(a1), .opdata2_i(b1),
    .start_i(start1), .annul_i(annul1), .result_o(res1), .ready_o(rdy1), .dbg_state(st1)
  );

  div_iter #(.DATA_W(W), .STEPS_PER_CYCLE(2)) dut2 (
    .clk(clk), .rst(rst), .signed_div_i(sgn2), .opdata1_i(a2), .opdata2_i(b2),
    .start_i(start2), .annul_i(annul2), .result_o(res2), .ready_o(rdy2), .dbg_state(st2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Plain-arithmetic reference: truncating division, remainder follows dividend.
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return '0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[W-1:0], q[W-1:0]};
  endfunction

  function automatic logic [2*W-1:0] cur_res(input int which);
    return (which == 0) ? res1 : res2;
  endfunction

  function automatic logic cur_rdy(input int which);
    return (which == 0) ? rdy1 : rdy2;
  endfunction

  function automatic div_state_e cur_st(input int which);
    return (which == 0) ? st1 : st2;
  endfunction

  task automatic drive(input int which, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic st, input logic an);
    if (which == 0) begin
      sgn1 = s; a1 = a; b1 = b; start1 = st; annul1 = an;
    end else begin
      sgn2 = s; a2 = a; b2 = b; start2 = st; annul2 = an;
    end
  endtask

  // Start a division, scramble operands after the start edge, wait for ready.
  // start stays high so the result is held in END on return.
  task automatic run_div(input string tag, input int which, input logic s,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    int edges;
    int exp_lat;
    logic [2*W-1:0] exp;
    exp_lat = (b == '0) ? 2 : ((which == 0) ? W + 1 : W / 2 + 1);
    exp_q.push_back(model(s, a, b));
    drive(which, s, a, b, 1'b1, 1'b0);
    tick();
    edges = 1;
    drive(which, ~s, $urandom, $urandom, 1'b1, 1'b0);
    while (!cur_rdy(which) && edges < 100) begin
      tick();
      edges++;
    end
    exp = exp_q.pop_front();
    check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
    check({tag, "_rdy"}, 64'(cur_rdy(which)), 64'd1);
    check({tag, "_res"}, cur_res(which), exp);
  endtask

  task automatic drop_start(input string tag, input int which);
    drive(which, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    check({tag, "_drop_rdy"}, 64'(cur_rdy(which)), 64'd0);
    check({tag, "_drop_res"}, cur_res(which), 64'd0);
    check({tag, "_drop_st"}, 64'(cur_st(which)), 64'(DIV_FREE));
  endtask

  initial begin
    logic [2*W-1:0] held;
    // reset
    rst = 1'b1;
    tick();
    tick();
    check("rst_rdy", 64'(rdy1), 64'd0);
    check("rst_res", res1, 64'd0);
    check("rst_st", 64'(st1), 64'(DIV_FREE));
    check("rst_st2", 64'(st2), 64'(DIV_FREE));
    rst = 1'b0;
    tick();

    // unsigned 100/7
    run_div("u100_7", 0, 1'b0, 32'd100, 32'd7);
    check("u100_7_const", res1, {32'h00000002, 32'h0000000E});
    drop_start("u100_7", 0);

    // signed and unsigned -7/2
    run_div("s_m7_2", 0, 1'b1, 32'hFFFFFFF9, 32'h2);
    check("s_m7_2_const", res1, {32'hFFFFFFFF, 32'hFFFFFFFD});
    drop_start("s_m7_2", 0);
    run_div("u_m7_2", 0, 1'b0, 32'hFFFFFFF9, 32'h2);
    check("u_m7_2_const", res1, {32'h00000001, 32'h7FFFFFFC});
    drop_start("u_m7_2", 0);

    // divide by zero
    run_div("s_by0", 0, 1'b1, 32'hDEADBEEF, 32'h0);
    drop_start("s_by0", 0);
    run_div("u_by0", 0, 1'b0, 32'h12345678, 32'h0);
    drop_start("u_by0", 0);

    // annul while in BYZERO
    drive(0, 1'b0, 32'd9, 32'd0, 1'b1, 1'b0);
    tick();
    check("byz_state", 64'(st1), 64'(DIV_BYZERO));
    drive(0, 1'b0, 32'd9, 32'd0, 1'b0, 1'b1);
    tick();
    check("byz_annul_st", 64'(st1), 64'(DIV_FREE));
    check("byz_annul_rdy", 64'(rdy1), 64'd0);
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("byz_annul_idle_rdy", 64'(rdy1), 64'd0);
    end

    // annul on the 10th ON cycle, then immediate restart
    drive(0, 1'b0, 32'h12345678, 32'h10, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(0, 1'b0, 32'h12345678, 32'h10, 1'b0, 1'b0);
      tick();
      check("on_no_rdy", 64'(rdy1), 64'd0);
    end
    check("on_state", 64'(st1), 64'(DIV_ON));
    drive(0, 1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    check("on_annul_st", 64'(st1), 64'(DIV_FREE));
    check("on_annul_rdy", 64'(rdy1), 64'd0);
    run_div("restart_50_5", 0, 1'b0, 32'd50, 32'd5);
    check("restart_const", res1, {32'd0, 32'd10});
    drop_start("restart", 0);

    // signed MIN / -1 at both step widths
    run_div("min_m1_s1", 0, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    check("min_m1_s1_const", res1, {32'h0, 32'h80000000});
    drop_start("min_m1_s1", 0);
    run_div("min_m1_s2", 1, 1'b1, 32'h80000000, 32'hFFFFFFFF);
    check("min_m1_s2_const", res2, {32'h0, 32'h80000000});
    drop_start("min_m1_s2", 1);

    // reset in the 5th ON cycle
    drive(0, 1'b0, 32'd1000, 32'd3, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    check("midrst_st", 64'(st1), 64'(DIV_FREE));
    check("midrst_rdy", 64'(rdy1), 64'd0);
    check("midrst_res", res1, 64'd0);
    tick();

    // start held through END keeps the result
    run_div("hold", 0, 1'b1, 32'hFFFF0001, 32'd13);
    held = model(1'b1, 32'hFFFF0001, 32'd13);
    for (int i = 0; i < 3; i++) begin
      drive(0, $urandom_range(0, 1), $urandom, $urandom, 1'b1, $urandom_range(0, 1));
      tick();
      check("hold_rdy", 64'(rdy1), 64'd1);
      check("hold_res", res1, held);
    end
    drop_start("hold", 0);

    // randomized operands on both instances
    for (int i = 0; i < 24; i++) begin
      logic s;
      logic [W-1:0] a, b;
      int which;
      which = i % 2;
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = W'($urandom_range(1, 15));
        2: b = -W'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div("rand", which, s, a, b);
      drop_start("rand", which);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
